dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data-memory block RAM between the CPU data port and a debug/loader port.
//  One access per cycle, CPU-priority arbitration with a starvation bound for the debug port.
//  Routes the 1-cycle-latency RAM read data back to the port that issued the read.
//  Snoops CPU writes to the tohost address and raises the pass/fail event the test harness monitors.
// PARAMETERS
//  RAM_AW      12        word-address width of the block RAM (4096 x 32b)
//  TOHOST_ADDR 32'h1000  byte address of the tohost register (full 32-bit compare)
//  STARVE_MAX  4         max consecutive cycles dbg_req may be refused before it is forced through (1..15)
// PORTS
//  sys_clk      in   1       clock, all state on rising edge
//  sys_rst_n    in   1       asynchronous active-low reset
//  cpu_req      in   1       CPU access request, held until cpu_gnt
//  cpu_addr     in   32      CPU byte address
//  cpu_we       in   4       CPU byte write enables; 4'b0000 = read
//  cpu_wdata    in   32      CPU write data
//  cpu_gnt      out  1       CPU access accepted this cycle (combinational)
//  cpu_rvalid   out  1       CPU read data valid (registered)
//  cpu_rdata    out  32      CPU read data
//  dbg_req      in   1       debug access request, held until dbg_gnt
//  dbg_addr     in   32      debug byte address
//  dbg_we       in   4       debug byte write enables; 4'b0000 = read
//  dbg_wdata    in   32      debug write data
//  dbg_gnt      out  1       debug access accepted this cycle (combinational)
//  dbg_rvalid   out  1       debug read data valid (registered)
//  dbg_rdata    out  32      debug read data
//  ram_en       out  1       block RAM enable
//  ram_we       out  4       block RAM byte write enables
//  ram_addr     out  RAM_AW  block RAM word address
//  ram_wdata    out  32      block RAM write data
//  ram_rdata    in   32      block RAM read data, valid 1 cycle after ram_en with ram_we==0
//  tohost_valid out  1       1-cycle pulse: CPU wrote tohost
//  tohost_data  out  32      value of the last CPU tohost write
//  tohost_done  out  1       sticky; set on first tohost write, cleared only by reset
// BEHAVIOUR
//  Reset (sys_rst_n=0, async): gnts=0, rvalids=0, rdatas=0, tohost_*=0, starve_cnt=0, rd_tag=NONE.
//  Arbitration per cycle, combinational from req and starve_cnt:
//   - only cpu_req -> cpu_gnt; only dbg_req -> dbg_gnt; neither -> ram_en=0.
//   - both, starve_cnt<STARVE_MAX -> cpu_gnt. Both, starve_cnt==STARVE_MAX -> dbg_gnt.
//   - at most one gnt per cycle.
//  starve_cnt: +1 on each cycle with dbg_req && !dbg_gnt. Cleared on dbg_gnt or when dbg_req=0.
//   Saturates at STARVE_MAX.
//  RAM drive: granted port muxed to ram_*; ram_en=gnt; ram_addr=addr[RAM_AW+1:2].
//   addr[1:0] and bits above RAM_AW+1 are ignored (aliasing is allowed).
//  Read return: rd_tag register records {CPU,DBG,NONE} for a granted read (we==0).
//   - Next cycle: the tagged port gets rvalid=1 with rdata=ram_rdata.
//   - The other rdata holds its last value.
//   - Back-to-back reads from either or alternating ports: one rvalid per cycle, no bubbles.
//   - Writes produce no rvalid.
//  tohost snoop: CPU grant with cpu_we!=0 and cpu_addr==TOHOST_ADDR:
//   - write still goes to RAM;
//   - next cycle: tohost_valid=1 and tohost_data=cpu_wdata; tohost_done set.
//   - debug-port writes to TOHOST_ADDR never trigger the snoop.
//  Reset asserted mid-operation: a pending rvalid is dropped, and no response is issued after release.
//  Requester contract: req/addr/we/wdata stable until gnt. Behaviour on violation is undefined.
// TESTING
//  1 dbg writes 32'hDEADBEEF @0x40 (we=F), then reads @0x40 -> dbg_rvalid next cycle, dbg_rdata=DEADBEEF, cpu_rvalid=0.
//  2 cpu_req,dbg_req both held high 10 cycles, STARVE_MAX=4 -> gnt pattern C,C,C,C,D, repeated; dbg never waits >4.
//  3 Alternating CPU/DBG reads every cycle, addrs 0x0/0x4 preloaded 11/22 -> each rvalid 1 cycle later on correct port, no bubbles.
//  4 cpu_we=4'b0010, wdata=32'hAABBCCDD @0x8 over 32'h0 -> readback 32'h0000CC00.
//  5 CPU writes 1 to 0x1000 -> tohost_valid pulse 1 cycle, tohost_data=1, tohost_done stays 1; a dbg write to 0x1000 gives no pulse.
//  6 sys_rst_n low the cycle after a granted read -> no rvalid; all outputs 0; arbitration resumes after release.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-port block RAM between the CPU
// data port and a debug/loader port, and snoops CPU writes to tohost.
//
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   cpu_req/addr/we/wdata     CPU request side; cpu_gnt (comb), cpu_rvalid/rdata
//   dbg_req/addr/we/wdata     debug request side; dbg_gnt (comb), dbg_rvalid/rdata
//   ram_en/we/addr/wdata      block RAM drive; ram_rdata returns 1 cycle later
//   tohost_valid/data/done    pulse, last value and sticky flag of CPU tohost writes
module dmem_port_arbiter #(
  parameter int          RAM_AW      = 12,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000,
  parameter int          STARVE_MAX  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  input  logic [3:0]        dbg_we,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              tohost_valid,
  output logic [31:0]       tohost_data,
  output logic              tohost_done
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_DBG  = 2'd2;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic [1:0]  rd_tag_q, rd_tag_d;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;
  logic        tohost_done_q, tohost_done_d;
  logic        force_dbg;
  logic        tohost_hit;

  // Byte-offset and high address bits are intentionally dropped.
  logic unused_dbg_addr;
  assign unused_dbg_addr = ^{dbg_addr[31:RAM_AW+2], dbg_addr[1:0]};

  // Grants are held low while reset is asserted.
  assign force_dbg = (starve_q == SMAX);
  assign cpu_gnt   = sys_rst_n && cpu_req && !(dbg_req && force_dbg);
  assign dbg_gnt   = sys_rst_n && dbg_req && (!cpu_req || force_dbg);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr[RAM_AW+1:2];
        ram_wdata = cpu_wdata;
      end
      dbg_gnt: begin
        ram_en    = 1'b1;
        ram_we    = dbg_we;
        ram_addr  = dbg_addr[RAM_AW+1:2];
        ram_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || dbg_gnt)
      starve_d = '0;
    else if (starve_q != SMAX)
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    rd_tag_d = TAG_NONE;
    if (cpu_gnt && cpu_we == 4'b0000)
      rd_tag_d = TAG_CPU;
    else if (dbg_gnt && dbg_we == 4'b0000)
      rd_tag_d = TAG_DBG;
  end

  assign tohost_hit = cpu_gnt && (cpu_we != 4'b0000)
                   && (cpu_addr == TOHOST_ADDR);

  always_comb begin
    tohost_valid_d = tohost_hit;
    tohost_data_d  = tohost_data_q;
    tohost_done_d  = tohost_done_q | tohost_hit;
    if (tohost_hit)
      tohost_data_d = cpu_wdata;
  end

  // rvalid is decoded straight from the tag register, so the returning
  // RAM data is forwarded in the same cycle and captured for holding.
  assign cpu_rvalid = (rd_tag_q == TAG_CPU);
  assign dbg_rvalid = (rd_tag_q == TAG_DBG);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : dbg_rdata_q;

  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
  assign tohost_done  = tohost_done_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve_q       <= '0;
      rd_tag_q       <= TAG_NONE;
      cpu_rdata_q    <= '0;
      dbg_rdata_q    <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      tohost_done_q  <= 1'b0;
    end else begin
      starve_q       <= starve_d;
      rd_tag_q       <= rd_tag_d;
      cpu_rdata_q    <= cpu_rdata;
      dbg_rdata_q    <= dbg_rdata;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
      tohost_done_q  <= tohost_done_d;
    end
  end

endmodule
